// File: rtl/ime_stream_pkg.sv
// Shared encodings for the IME ingress stream: BIST status codes, the frame
// transmitter state set, error flag bit positions and the mode decoder.
package ime_stream_pkg;

   localparam logic [1:0] BIST_IDLE    = 2'b00;
   localparam logic [1:0] BIST_RUNNING = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_PAUSE
   } tx_state_e;

   localparam int ERR_BAD_MODE   = 0;
   localparam int ERR_CREDIT_OVF = 1;
   localparam int ERR_POISON     = 2;
   localparam int ERR_BIST_PAUSE = 3;

   // Caller truncates to the mode field width.
   function automatic logic [31:0] mode_onehot(input int unsigned idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/ime_credit_counter.sv
// Saturating up/down credit pool. Simultaneous up and down leave the count
// unchanged; an up request at all-ones holds the count and pulses overflow.
module ime_credit_counter #(
   parameter int                WIDTH = 16,
   parameter logic [WIDTH-1:0]  INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MAX = '1;

   function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] c,
                                                 input logic up,
                                                 input logic dn);
      if (up && !dn) return (c == MAX) ? c : c + 1'b1;
      if (dn && !up) return (c == '0) ? c : c - 1'b1;
      return c;
   endfunction

   assign overflow = inc && !dec && (count == MAX);

   always_ff @(posedge clk) begin
      if (rst) count <= INIT;
      else     count <= sat_step(count, inc, dec);
   end

endmodule

// File: rtl/ime_frame_tx.sv
// IME ingress frame transmitter: turns frame commands and a payload feed into
// credit-metered AXI-Stream frames with a one-hot mode in tuser.
module ime_frame_tx
   import ime_stream_pkg::*;
#(
   parameter int W_DATA       = 32,
   parameter int W_USER       = 8,
   parameter int MODE_WIDTH   = 3,
   parameter int MODE_LSB     = 0,
   parameter int W_LEN        = 16,
   parameter int CREDIT_WIDTH = 16,
   parameter int CREDIT_INIT  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [$clog2(MODE_WIDTH)-1:0] cmd_mode,
   input  logic [W_LEN-1:0]              cmd_len,
   input  logic                          src_valid,
   output logic                          src_ready,
   input  logic [W_DATA-1:0]             src_data,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [W_DATA-1:0]             m_axis_tdata,
   output logic [W_USER-1:0]             m_axis_tuser,
   output logic                          m_axis_tlast,
   input  logic                          credit_return,
   output logic [CREDIT_WIDTH-1:0]       credit_depth,
   input  logic                          poison_flag,
   input  logic [1:0]                    bist_status,
   input  logic                          err_clear,
   output logic [3:0]                    error_flags
);

   tx_state_e               state;
   tx_state_e               resume_state;
   logic                    rdy_q;
   logic [W_LEN:0]          beats_left;
   logic [MODE_WIDTH-1:0]   mode_oh;
   logic                    poison_sticky;
   logic [3:0]              err_q;
   logic [3:0]              err_next;
   logic [W_USER-1:0]       user_word;

   logic                    vld_p1;
   logic                    last_p1;
   logic [W_DATA-1:0]       data_p1;
   logic [W_USER-1:0]       user_p1;

   logic bist_run, in_frame, fire, load, credit_ok, cmd_acc, bad_mode, credit_ovf;

   assign bist_run  = (bist_status == BIST_RUNNING);
   assign in_frame  = (state == ST_LOAD) || (state == ST_SEND);
   assign fire      = vld_p1 && m_axis_tready && !bist_run;
   // A held beat already owns one credit, so a new load needs one more.
   assign credit_ok = credit_depth > CREDIT_WIDTH'(vld_p1);
   assign src_ready = in_frame && !bist_run && (beats_left != '0) &&
                      (!vld_p1 || fire) && credit_ok;
   assign load      = src_valid && src_ready;
   assign cmd_ready = rdy_q && !bist_run;
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign bad_mode  = 32'(cmd_mode) >= MODE_WIDTH;

   always_comb begin
      user_word = '0;
      user_word[MODE_LSB +: MODE_WIDTH] = mode_oh;
   end

   always_comb begin
      err_next = err_clear ? 4'b0000 : err_q;
      if (cmd_acc && bad_mode)                    err_next[ERR_BAD_MODE]   = 1'b1;
      if (credit_ovf)                             err_next[ERR_CREDIT_OVF] = 1'b1;
      if (poison_flag && (state != ST_IDLE || vld_p1)) err_next[ERR_POISON] = 1'b1;
      if (bist_run && in_frame)                   err_next[ERR_BIST_PAUSE] = 1'b1;
   end

   ime_credit_counter #(
      .WIDTH (CREDIT_WIDTH),
      .INIT  (CREDIT_WIDTH'(CREDIT_INIT))
   ) u_credit (
      .clk      (clk),
      .rst      (rst),
      .inc      (credit_return),
      .dec      (fire),
      .count    (credit_depth),
      .overflow (credit_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         resume_state  <= ST_IDLE;
         rdy_q         <= 1'b0;
         beats_left    <= '0;
         mode_oh       <= '0;
         poison_sticky <= 1'b0;
         err_q         <= 4'b0000;
         vld_p1        <= 1'b0;
         last_p1       <= 1'b0;
         data_p1       <= '0;
         user_p1       <= '0;
      end else begin
         err_q <= err_next;

         // Stage p1: output register, refilled in the cycle it drains
         if (fire) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
         end
         if (load) begin
            vld_p1     <= 1'b1;
            last_p1    <= (beats_left == (W_LEN+1)'(1));
            data_p1    <= src_data;
            user_p1    <= user_word;
            beats_left <= beats_left - 1'b1;
         end

         if (fire && last_p1)                        poison_sticky <= 1'b0;
         else if (poison_flag && state != ST_IDLE)   poison_sticky <= 1'b1;

         case (state)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (cmd_acc && !bad_mode) begin
                  mode_oh    <= MODE_WIDTH'(mode_onehot(32'(cmd_mode)));
                  beats_left <= {1'b0, cmd_len} + 1'b1;
                  rdy_q      <= 1'b0;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD, ST_SEND: begin
               if (bist_run) begin
                  resume_state <= state;
                  state        <= ST_PAUSE;
               end else if (fire && last_p1) begin
                  state <= ST_IDLE;
                  rdy_q <= 1'b1;
               end else if (load) begin
                  state <= ST_SEND;
               end
            end
            ST_PAUSE: begin
               if (!bist_run) begin
                  if (fire && last_p1) begin
                     state <= ST_IDLE;
                     rdy_q <= 1'b1;
                  end else begin
                     state <= resume_state;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m_axis_tvalid = vld_p1 && !bist_run;
   assign m_axis_tdata  = (poison_flag || poison_sticky) ? '0 : data_p1;
   assign m_axis_tuser  = user_p1;
   assign m_axis_tlast  = last_p1;
   assign error_flags   = err_q;

endmodule

// File: tb/tb_ime_frame_tx.sv
// Directed bench for ime_frame_tx: three instances differing only in initial
// credit pool, driven in common and observed through a selectable view.
module tb_ime_frame_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_mode = 2'd0;
   logic [15:0] cmd_len = 16'd0;
   logic        src_valid = 1'b0;
   logic [31:0] src_data = 32'd0;
   logic        m_axis_tready = 1'b0;
   logic        credit_return = 1'b0;
   logic        poison_flag = 1'b0;
   logic [1:0]  bist_status = 2'b00;
   logic        err_clear = 1'b0;

   logic        cmd_ready_o [3];
   logic        src_ready_o [3];
   logic        tvalid_o    [3];
   logic        tlast_o     [3];
   logic [31:0] tdata_o     [3];
   logic [7:0]  tuser_o     [3];
   logic [15:0] depth_o     [3];
   logic [3:0]  err_o       [3];

   always #5 clk = ~clk;

   ime_frame_tx #(.CREDIT_INIT(16)) u_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
      .cmd_mode(cmd_mode), .cmd_len(cmd_len), .src_valid(src_valid),
      .src_ready(src_ready_o[0]), .src_data(src_data), .m_axis_tvalid(tvalid_o[0]),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(tdata_o[0]), .m_axis_tuser(tuser_o[0]),
      .m_axis_tlast(tlast_o[0]), .credit_return(credit_return), .credit_depth(depth_o[0]),
      .poison_flag(poison_flag), .bist_status(bist_status), .err_clear(err_clear),
      .error_flags(err_o[0]));

   ime_frame_tx #(.CREDIT_INIT(2)) u_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
      .cmd_mode(cmd_mode), .cmd_len(cmd_len), .src_valid(src_valid),
      .src_ready(src_ready_o[1]), .src_data(src_data), .m_axis_tvalid(tvalid_o[1]),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(tdata_o[1]), .m_axis_tuser(tuser_o[1]),
      .m_axis_tlast(tlast_o[1]), .credit_return(credit_return), .credit_depth(depth_o[1]),
      .poison_flag(poison_flag), .bist_status(bist_status), .err_clear(err_clear),
      .error_flags(err_o[1]));

   ime_frame_tx #(.CREDIT_INIT(65535)) u_c (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[2]),
      .cmd_mode(cmd_mode), .cmd_len(cmd_len), .src_valid(src_valid),
      .src_ready(src_ready_o[2]), .src_data(src_data), .m_axis_tvalid(tvalid_o[2]),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(tdata_o[2]), .m_axis_tuser(tuser_o[2]),
      .m_axis_tlast(tlast_o[2]), .credit_return(credit_return), .credit_depth(depth_o[2]),
      .poison_flag(poison_flag), .bist_status(bist_status), .err_clear(err_clear),
      .error_flags(err_o[2]));

   logic [1:0]  sel = 2'd0;
   logic        mon_cmd_ready, mon_src_ready, mon_tvalid, mon_tlast;
   logic [31:0] mon_tdata;
   logic [7:0]  mon_tuser;
   logic [15:0] mon_depth;
   logic [3:0]  mon_err;

   always_comb begin
      mon_cmd_ready = cmd_ready_o[sel];
      mon_src_ready = src_ready_o[sel];
      mon_tvalid    = tvalid_o[sel];
      mon_tlast     = tlast_o[sel];
      mon_tdata     = tdata_o[sel];
      mon_tuser     = tuser_o[sel];
      mon_depth     = depth_o[sel];
      mon_err       = err_o[sel];
   end

   logic [31:0] cap_data [$];
   logic        cap_last [$];
   logic [7:0]  cap_user [$];
   logic [31:0] src_tab [8];
   int          src_idx, src_n;
   logic        saw_tvalid;
   int          n_vec = 0;
   int          n_bad = 0;

   // One clock: present source data, record handshakes, advance to the next negedge.
   task automatic clk_cycle();
      logic cmd_hs;
      src_valid = (src_idx < src_n);
      src_data  = src_tab[src_idx[2:0]];
      #1;
      cmd_hs = cmd_valid && mon_cmd_ready;
      if (src_valid && mon_src_ready) src_idx++;
      if (mon_tvalid) saw_tvalid = 1'b1;
      if (mon_tvalid && m_axis_tready) begin
         cap_data.push_back(mon_tdata);
         cap_last.push_back(mon_tlast);
         cap_user.push_back(mon_tuser);
      end
      @(negedge clk);
      if (cmd_hs) cmd_valid = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) clk_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; src_valid = 1'b0; credit_return = 1'b0;
      poison_flag = 1'b0; bist_status = 2'b00; err_clear = 1'b0;
      m_axis_tready = 1'b1;
      src_n = 0; src_idx = 0; saw_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic new_frame(input logic [1:0] mode, input logic [15:0] len, input int n);
      cap_data.delete(); cap_last.delete(); cap_user.delete();
      src_idx = 0; src_n = n; saw_tvalid = 1'b0;
      cmd_mode = mode; cmd_len = len; cmd_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({tvalid_o[i], tlast_o[i], cmd_ready_o[i], src_ready_o[i]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl[%0d]: got %b expected 0000", i,
                     {tvalid_o[i], tlast_o[i], cmd_ready_o[i], src_ready_o[i]});
         end
         n_vec++;
         if ({tuser_o[i], tdata_o[i], err_o[i]} !== 44'd0) begin
            n_bad++;
            $display("FAIL reset_regs[%0d]: got %h expected 0", i, {tuser_o[i], tdata_o[i], err_o[i]});
         end
      end
      n_vec++;
      if (depth_o[0] !== 16'd16) begin n_bad++; $display("FAIL reset_depth_a: got %0d expected 16", depth_o[0]); end
      n_vec++;
      if (depth_o[1] !== 16'd2) begin n_bad++; $display("FAIL reset_depth_b: got %0d expected 2", depth_o[1]); end
      n_vec++;
      if (depth_o[2] !== 16'hFFFF) begin n_bad++; $display("FAIL reset_depth_c: got %h expected ffff", depth_o[2]); end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (cmd_ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready_o[0]); end
   endtask

   task automatic test_basic_frame();
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 8; i++) src_tab[i] = 32'hA000_0001 + i;
      new_frame(2'd1, 16'd3, 4);
      run(12);
      n_vec++;
      if (cap_data.size() !== 4) begin n_bad++; $display("FAIL basic_beats: got %0d expected 4", cap_data.size()); end
      for (int i = 0; i < cap_data.size(); i++) begin
         n_vec++;
         if ({cap_data[i], cap_user[i], cap_last[i]} !== {32'hA000_0001 + i, 8'h02, (i == 3)}) begin
            n_bad++;
            $display("FAIL basic_beat%0d: got %h/%h/%b expected %h/02/%b", i,
                     cap_data[i], cap_user[i], cap_last[i], 32'hA000_0001 + i, (i == 3));
         end
      end
      n_vec++;
      if (mon_depth !== 16'd12) begin n_bad++; $display("FAIL basic_depth: got %0d expected 12", mon_depth); end
      n_vec++;
      if (mon_err !== 4'b0000) begin n_bad++; $display("FAIL basic_err: got %b expected 0000", mon_err); end
   endtask

   task automatic test_credit_stall();
      sel = 2'd1;
      do_reset();
      for (int i = 0; i < 8; i++) src_tab[i] = 32'hB100_0000 + i;
      new_frame(2'd0, 16'd4, 5);
      run(10);
      n_vec++;
      if (cap_data.size() !== 2) begin n_bad++; $display("FAIL stall_beats: got %0d expected 2", cap_data.size()); end
      n_vec++;
      if (mon_tvalid !== 1'b0) begin n_bad++; $display("FAIL stall_tvalid: got %b expected 0", mon_tvalid); end
      n_vec++;
      if (mon_depth !== 16'd0) begin n_bad++; $display("FAIL stall_depth: got %0d expected 0", mon_depth); end
      repeat (3) begin
         credit_return = 1'b1;
         clk_cycle();
         credit_return = 1'b0;
         clk_cycle();
      end
      run(10);
      n_vec++;
      if (cap_data.size() !== 5) begin n_bad++; $display("FAIL resume_beats: got %0d expected 5", cap_data.size()); end
      for (int i = 0; i < cap_data.size(); i++) begin
         n_vec++;
         if ({cap_data[i], cap_user[i], cap_last[i]} !== {32'hB100_0000 + i, 8'h01, (i == 4)}) begin
            n_bad++;
            $display("FAIL resume_beat%0d: got %h/%h/%b expected %h/01/%b", i,
                     cap_data[i], cap_user[i], cap_last[i], 32'hB100_0000 + i, (i == 4));
         end
      end
      n_vec++;
      if (mon_depth !== 16'd0) begin n_bad++; $display("FAIL resume_depth: got %0d expected 0", mon_depth); end
   endtask

   task automatic test_poison();
      logic done;
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 8; i++) src_tab[i] = 32'hC0DE_0010 + i;
      new_frame(2'd2, 16'd4, 5);
      done = 1'b0;
      repeat (16) begin
         poison_flag = !done && (cap_data.size() == 1) && mon_tvalid;
         if (poison_flag) done = 1'b1;
         clk_cycle();
         poison_flag = 1'b0;
      end
      n_vec++;
      if (cap_data.size() !== 5) begin n_bad++; $display("FAIL poison_beats: got %0d expected 5", cap_data.size()); end
      for (int i = 0; i < cap_data.size(); i++) begin
         n_vec++;
         if ({cap_data[i], cap_user[i], cap_last[i]} !==
             {(i == 0) ? 32'hC0DE_0010 : 32'd0, 8'h04, (i == 4)}) begin
            n_bad++;
            $display("FAIL poison_beat%0d: got %h/%h/%b expected %h/04/%b", i, cap_data[i],
                     cap_user[i], cap_last[i], (i == 0) ? 32'hC0DE_0010 : 32'd0, (i == 4));
         end
      end
      n_vec++;
      if (mon_err !== 4'b0100) begin n_bad++; $display("FAIL poison_err: got %b expected 0100", mon_err); end
      new_frame(2'd2, 16'd0, 1);
      run(6);
      n_vec++;
      if (cap_data.size() !== 1 || cap_data[0] !== 32'hC0DE_0010) begin
         n_bad++;
         $display("FAIL poison_next_frame: got %0d beats first %h expected 1 beat c0de0010",
                  cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 32'd0);
      end
   endtask

   task automatic test_bist_pause();
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 8; i++) src_tab[i] = 32'hD000_0100 + i;
      new_frame(2'd1, 16'd4, 5);
      for (int c = 0; c < 20 && !(cap_data.size() == 2 && mon_tvalid); c++) clk_cycle();
      m_axis_tready = 1'b0;
      bist_status = 2'b01;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++;
         if (mon_tvalid !== 1'b0) begin n_bad++; $display("FAIL bist_tvalid_c%0d: got %b expected 0", c, mon_tvalid); end
         clk_cycle();
      end
      bist_status = 2'b00;
      #1;
      n_vec++;
      if ({mon_tvalid, mon_tdata} !== {1'b1, 32'hD000_0102}) begin
         n_bad++;
         $display("FAIL bist_represent: got %b/%h expected 1/d0000102", mon_tvalid, mon_tdata);
      end
      clk_cycle();
      m_axis_tready = 1'b1;
      run(12);
      n_vec++;
      if (cap_data.size() !== 5) begin n_bad++; $display("FAIL bist_beats: got %0d expected 5", cap_data.size()); end
      for (int i = 0; i < cap_data.size(); i++) begin
         n_vec++;
         if ({cap_data[i], cap_last[i]} !== {32'hD000_0100 + i, (i == 4)}) begin
            n_bad++;
            $display("FAIL bist_beat%0d: got %h/%b expected %h/%b", i, cap_data[i], cap_last[i],
                     32'hD000_0100 + i, (i == 4));
         end
      end
      n_vec++;
      if (mon_err !== 4'b1000) begin n_bad++; $display("FAIL bist_err: got %b expected 1000", mon_err); end
   endtask

   task automatic test_bad_mode();
      sel = 2'd0;
      do_reset();
      new_frame(2'd3, 16'd0, 0);
      run(6);
      n_vec++;
      if ({cmd_valid, saw_tvalid, mon_err} !== {1'b0, 1'b0, 4'b0001}) begin
         n_bad++;
         $display("FAIL bad_mode: got pending=%b tvalid_seen=%b err=%b expected 0/0/0001",
                  cmd_valid, saw_tvalid, mon_err);
      end
      n_vec++;
      if (mon_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bad_mode_idle: got %b expected 1", mon_cmd_ready); end
      err_clear = 1'b1;
      clk_cycle();
      err_clear = 1'b0;
      n_vec++;
      if (mon_err !== 4'b0000) begin n_bad++; $display("FAIL err_clear: got %b expected 0000", mon_err); end
      err_clear = 1'b1;
      new_frame(2'd3, 16'd0, 0);
      clk_cycle();
      err_clear = 1'b0;
      n_vec++;
      if (mon_err !== 4'b0001) begin n_bad++; $display("FAIL clear_vs_set: got %b expected 0001", mon_err); end
   endtask

   task automatic test_credit_sat();
      sel = 2'd2;
      do_reset();
      credit_return = 1'b1;
      clk_cycle();
      credit_return = 1'b0;
      n_vec++;
      if ({mon_depth, mon_err} !== {16'hFFFF, 4'b0010}) begin
         n_bad++;
         $display("FAIL sat_return: got %h/%b expected ffff/0010", mon_depth, mon_err);
      end
      err_clear = 1'b1;
      clk_cycle();
      err_clear = 1'b0;
      src_tab[0] = 32'h5A5A_0001;
      new_frame(2'd0, 16'd0, 1);
      repeat (8) begin
         credit_return = mon_tvalid && (cap_data.size() == 0);
         clk_cycle();
         credit_return = 1'b0;
      end
      n_vec++;
      if ({cap_data.size() == 1, mon_depth, mon_err} !== {1'b1, 16'hFFFF, 4'b0000}) begin
         n_bad++;
         $display("FAIL sat_fire_return: got beats=%0d depth=%h err=%b expected 1/ffff/0000",
                  cap_data.size(), mon_depth, mon_err);
      end
      sel = 2'd0;
      do_reset();
      src_tab[0] = 32'h1; src_tab[1] = 32'h2;
      new_frame(2'd0, 16'd1, 2);
      repeat (8) begin
         credit_return = mon_tvalid && (cap_data.size() == 0);
         clk_cycle();
         credit_return = 1'b0;
      end
      n_vec++;
      if ({cap_data.size() == 2, mon_depth} !== {1'b1, 16'd15}) begin
         n_bad++;
         $display("FAIL fire_return_depth: got beats=%0d depth=%0d expected 2/15", cap_data.size(), mon_depth);
      end
   endtask

   task automatic test_reset_mid_frame();
      sel = 2'd0;
      do_reset();
      for (int i = 0; i < 8; i++) src_tab[i] = 32'hE000_0000 + i;
      new_frame(2'd1, 16'd7, 8);
      run(4);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({mon_tvalid, mon_tlast, mon_depth} !== {1'b0, 1'b0, 16'd16}) begin
         n_bad++;
         $display("FAIL mid_reset: got %b/%b/%0d expected 0/0/16", mon_tvalid, mon_tlast, mon_depth);
      end
      rst = 1'b0;
      cmd_valid = 1'b0;
      src_n = 0;
      @(negedge clk);
   endtask

   initial begin
      src_idx = 0; src_n = 0; saw_tvalid = 1'b0;
      for (int i = 0; i < 8; i++) src_tab[i] = 32'd0;
      test_reset();
      test_basic_frame();
      test_credit_stall();
      test_poison();
      test_bist_pause();
      test_bad_mode();
      test_credit_sat();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
